uart_wb_bridge: RTL and testbench

//  Byte-stream-to-Wishbone master: decodes the host debug protocol (cmd, size, address, data)
//  and runs single or burst Wishbone reads and writes. Sits behind the UART RX/TX byte cores.

---
 rtl/uart_wb_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_uart_wb_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: host debug byte protocol to Wishbone master.
// Frame: cmd (0x01 write / 0x02 read), size N, address MSB first, then N write words MSB first.
// Build option: define UWB_TIMEOUT_EN to abort bus cycles that see no ack within TIMEOUT_CYC cycles.
module uart_wb_bridge #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    input  logic [DATA_W-1:0]     wbm_dat_i,
    input  logic                  wbm_ack_i,
    output logic                  busy_o,
    output logic [1:0]            err_o
);
    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned AB   = ADDR_W / 8;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [7:0]        AB_LAST  = 8'(AB - 1);
    localparam logic [7:0]        NB_LAST  = 8'(NB - 1);
    localparam logic [ADDR_W-1:0] ADR_STEP = ADDR_W'(NB);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
`ifdef UWB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_SIZE, S_ADDR, S_WDATA, S_RBUS, S_RSEND
    } state_t;

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              cyc_q, cyc_d;
    logic              go_q, go_d;
    logic [1:0]        err_q, err_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic bus_ack, timeout_hit, bus_done;

    assign bus_ack     = cyc_q && wbm_ack_i;
    assign timeout_hit = TO_EN && cyc_q && !wbm_ack_i && (to_cnt_q == TO_LAST);
    assign bus_done    = bus_ack || timeout_hit;

    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = cyc_q && wr_q;
    assign wbm_sel_o  = '1;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_q;
    assign tx_data_o  = asm_q[DATA_W-1 -: 8];
    assign tx_valid_o = (state_q == S_RSEND);
    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;

    // State and datapath registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            n_q      <= '0;
            cnt_q    <= '0;
            adr_q    <= '0;
            asm_q    <= '0;
            dat_q    <= '0;
            cyc_q    <= 1'b0;
            go_q     <= 1'b0;
            err_q    <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            asm_q    <= asm_d;
            dat_q    <= dat_d;
            cyc_q    <= cyc_d;
            go_q     <= go_d;
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Frame decoding, bus sequencing and tx serialisation
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        asm_d    = asm_q;
        dat_d    = dat_q;
        cyc_d    = cyc_q;
        go_d     = go_q;
        err_d    = err_q;
        to_cnt_d = '0;

        if (TO_EN && cyc_q && !bus_done) to_cnt_d = to_cnt_q + TO_W'(1);
        if (timeout_hit) err_d[0] = 1'b1;
        if (bus_done)    cyc_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid_i && (rx_data_i == 8'h01 || rx_data_i == 8'h02)) begin
                    wr_d    = (rx_data_i == 8'h01);
                    err_d   = '0;
                    state_d = S_SIZE;
                end
            end
            S_SIZE: begin
                if (rx_valid_i) begin
                    n_d     = rx_data_i;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_valid_i) begin
                    adr_d = (adr_q << 8) | ADDR_W'(rx_data_i);
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == AB_LAST) begin
                        cnt_d = '0;
                        if (n_q == 8'd0) begin
                            state_d = S_IDLE;
                        end else if (wr_q) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d = S_RBUS;
                            cyc_d   = 1'b1;
                        end
                    end
                end
            end
            S_WDATA: begin
                // A word finished in an ack cycle is parked in go_q so cyc stays low for one cycle.
                if (go_q) begin
                    cyc_d = 1'b1;
                    go_d  = 1'b0;
                end
                if (rx_valid_i) begin
                    asm_d = (asm_q << 8) | DATA_W'(rx_data_i);
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == NB_LAST) begin
                        cnt_d = '0;
                        if ((cyc_q && !bus_done) || go_q) begin
                            err_d[1] = 1'b1;
                        end else if (cyc_q) begin
                            dat_d = (asm_q << 8) | DATA_W'(rx_data_i);
                            go_d  = 1'b1;
                        end else begin
                            dat_d = (asm_q << 8) | DATA_W'(rx_data_i);
                            cyc_d = 1'b1;
                        end
                    end
                end
                if (bus_done) begin
                    adr_d = adr_q + ADR_STEP;
                    n_d   = n_q - 8'd1;
                    if (n_q == 8'd1) begin
                        state_d = S_IDLE;
                        go_d    = 1'b0;
                    end
                end
            end
            S_RBUS: begin
                if (bus_done) begin
                    asm_d   = bus_ack ? wbm_dat_i : {NB{8'hEE}};
                    cnt_d   = '0;
                    state_d = S_RSEND;
                end
            end
            S_RSEND: begin
                if (tx_ready_i) begin
                    asm_d = asm_q << 8;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == NB_LAST) begin
                        cnt_d = '0;
                        adr_d = adr_q + ADR_STEP;
                        n_d   = n_q - 8'd1;
                        if (n_q == 8'd1) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_RBUS;
                            cyc_d   = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge: memory reference model, Wishbone slave, tx sink.
module tb_uart_wb_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = '0;
    logic        ack = 1'b0;
    logic        busy;
    logic [1:0]  err;

    int n_cmp = 0;
    int n_bad = 0;
    int tx_popped = 0;
    bit ack_en = 1'b1;
    bit hold_ready = 1'b0;

    typedef struct { bit we; logic [31:0] adr; logic [31:0] dat; } wb_exp_t;
    wb_exp_t     exp_wb[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    uart_wb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(1024)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endfunction

    // Wishbone slave: random wait states, memory separate from the reference model
    initial begin : slave
        int wait_left;
        wait_left = -1;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                ack = 1'b0; wait_left = -1;
            end else if (ack) begin
                ack = 1'b0;
            end else if (cyc && stb && ack_en) begin
                if (wait_left < 0) wait_left = int'($urandom_range(0, 3));
                if (wait_left == 0) begin
                    ack = 1'b1; wait_left = -1;
                    if (we) slv_mem[adr] = dat_o;
                    else    dat_i = slv_mem.exists(adr) ? slv_mem[adr] : init_word(adr);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Tx sink with random back-pressure
    initial begin : tx_sink
        forever begin
            @(posedge clk); #1;
            tx_ready = !hold_ready && ($urandom_range(0, 3) != 0);
        end
    end

    // Bus monitor
    initial begin : wb_mon
        bit ack_prev;
        wb_exp_t e;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ack_prev = 1'b0;
            end else begin
                if (ack_prev) chk("wb_idle_after_ack", 64'(cyc), 64'(0));
                if (cyc && ack) begin
                    chk("wb_stb", 64'(stb), 64'(1));
                    chk("wb_sel", 64'(sel), 64'(4'hF));
                    if (exp_wb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL wb_unexpected: got cycle we=%0b adr=%08h, required none", we, adr);
                    end else begin
                        e = exp_wb.pop_front();
                        chk("wb_we", 64'(we), 64'(e.we));
                        chk("wb_adr", 64'(adr), 64'(e.adr));
                        if (e.we) chk("wb_dat", 64'(dat_o), 64'(e.dat));
                    end
                end
                ack_prev = cyc && ack;
            end
        end
    end

    // Tx monitor
    initial begin : tx_mon
        bit hold_prev;
        logic [7:0] data_prev;
        hold_prev = 1'b0; data_prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("tx_valid_held", 64'(tx_valid), 64'(1));
                    chk("tx_data_stable", 64'(tx_data), 64'(data_prev));
                end
                if (tx_valid && tx_ready) begin
                    tx_popped++;
                    if (exp_tx.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL tx_unexpected: got byte %02h, required none", tx_data);
                    end else begin
                        chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
                    end
                end
                hold_prev = tx_valid && !tx_ready;
                data_prev = tx_data;
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk); rx_data = b; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 3; i >= 0; i--) send(w[8*i +: 8], int'($urandom_range(0, max_gap)));
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [7:0] n, input logic [31:0] a);
        send(cmd, int'($urandom_range(0, 2)));
        send(n, int'($urandom_range(0, 2)));
        for (int i = 3; i >= 0; i--) send(a[8*i +: 8], (i == 0) ? 0 : int'($urandom_range(0, 2)));
    endtask

    task automatic do_write(input logic [31:0] a0, input int n, input bit fixed, input logic [31:0] fw);
        logic [31:0] a, w;
        a = a0;
        send_hdr(8'h01, 8'(n), a0);
        for (int k = 0; k < n; k++) begin
            w = fixed ? fw : $urandom;
            ref_mem[a] = w;
            exp_wb.push_back('{1'b1, a, w});
            send_word(w, 2);
            a = a + 32'd4;
        end
    endtask

    task automatic do_read(input logic [31:0] a0, input int n);
        logic [31:0] a, w;
        a = a0;
        for (int k = 0; k < n; k++) begin
            w = ref_rd(a);
            exp_wb.push_back('{1'b0, a, w});
            for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
            a = a + 32'd4;
        end
        send_hdr(8'h02, 8'(n), a0);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int c;
        bit idle;
        c = 0;
        idle = !busy && exp_wb.size() == 0 && exp_tx.size() == 0;
        while (!idle && c < budget) begin
            @(negedge clk);
            c++;
            idle = !busy && exp_wb.size() == 0 && exp_tx.size() == 0;
        end
        n_cmp++;
        if (!idle) begin
            n_bad++;
            $display("FAIL %s: busy=%0b wb_pending=%0d tx_pending=%0d after %0d cycles, required idle",
                     nm, busy, exp_wb.size(), exp_tx.size(), c);
            exp_wb.delete();
            exp_tx.delete();
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] a, w1, w2, w3;
        int n, c, base;

        repeat (3) @(negedge clk);
        chk("rst_cyc", 64'(cyc), 64'(0));
        chk("rst_stb", 64'(stb), 64'(0));
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_sel", 64'(sel), 64'(4'hF));
        chk("rst_adr", 64'(adr), 64'(0));
        chk("rst_dat", 64'(dat_o), 64'(0));
        chk("rst_tx_valid", 64'(tx_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single write then read-back, with read latency check
        do_write(32'h0000_0110, 1, 1'b1, 32'h7755_55AB);
        wait_idle("single_write", 200);
        do_read(32'h0000_0110, 1);
        chk("rd_latency_cyc", 64'(cyc), 64'(1));
        wait_idle("single_read", 300);
        chk("busy_after_read", 64'(busy), 64'(0));

        // Burst write with auto-increment, then burst read-back
        do_write(32'h0000_0100, 3, 1'b0, '0);
        wait_idle("burst_write", 400);
        do_read(32'h0000_0100, 3);
        wait_idle("burst_read", 600);

        // Stray byte and size-0 read produce no bus traffic
        send(8'h07, 1);
        do_read(32'h0000_0040, 0);
        wait_idle("size0_read", 50);
        chk("size0_busy", 64'(busy), 64'(0));
        do_read(32'h0000_0110, 1);
        wait_idle("read_after_size0", 300);

        // Tx back-pressure mid-word
        base = tx_popped;
        do_read(32'h0000_0100, 2);
        c = 0;
        while (tx_popped < base + 2 && c < 400) begin @(negedge clk); c++; end
        chk("stall_reached_mid_word", 64'(tx_popped >= base + 2), 64'(1));
        hold_ready = 1'b1;
        repeat (50) @(negedge clk);
        chk("stall_tx_valid", 64'(tx_valid), 64'(1));
        hold_ready = 1'b0;
        wait_idle("stall_read", 400);

        // Overrun: second word completes while first cycle is unacked
        a = 32'h0000_0300;
        ack_en = 1'b0;
        send_hdr(8'h01, 8'd2, a);
        w1 = $urandom; w2 = $urandom; w3 = $urandom;
        ref_mem[a] = w1;
        exp_wb.push_back('{1'b1, a, w1});
        send_word(w1, 0);
        repeat (3) @(negedge clk);
        chk("ovr_pending_cyc", 64'(cyc), 64'(1));
        send_word(w2, 0);
        chk("ovr_err", 64'(err), 64'(2'b10));
        ack_en = 1'b1;
        c = 0;
        while (exp_wb.size() != 0 && c < 50) begin @(negedge clk); c++; end
        chk("ovr_first_acked", 64'(exp_wb.size()), 64'(0));
        ref_mem[a + 32'd4] = w3;
        exp_wb.push_back('{1'b1, a + 32'd4, w3});
        send_word(w3, 1);
        wait_idle("ovr_write", 200);
        chk("ovr_err_sticky", 64'(err), 64'(2'b10));
        do_read(a, 2);
        wait_idle("ovr_readback", 400);
        chk("err_cleared_by_cmd", 64'(err), 64'(0));

        // Address wrap
        do_write(32'hFFFF_FFFC, 2, 1'b0, '0);
        wait_idle("wrap_write", 300);
        do_read(32'hFFFF_FFFC, 2);
        wait_idle("wrap_read", 400);

        // Random frames
        for (int f = 0; f < 12; f++) begin
            a = 32'h0000_0200 + 32'(4 * $urandom_range(0, 15));
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) do_write(a, n, 1'b0, '0);
            else                            do_read(a, n);
            wait_idle("rand_frame", 600);
        end

        // Slave never acks
        ack_en = 1'b0;
`ifdef UWB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'hEE);
        send_hdr(8'h02, 8'd1, 32'h0000_0500);
        wait_idle("timeout_read", 1500);
        chk("timeout_err", 64'(err), 64'(2'b01));
        chk("timeout_cyc", 64'(cyc), 64'(0));
        send_hdr(8'h02, 8'd1, 32'h0000_0504);
        repeat (20) @(negedge clk);
`else
        send_hdr(8'h02, 8'd1, 32'h0000_0500);
        repeat (1100) @(negedge clk);
        chk("noack_cyc_held", 64'(cyc), 64'(1));
        chk("noack_busy", 64'(busy), 64'(1));
        chk("noack_err", 64'(err), 64'(0));
`endif
        // Asynchronous reset while a cycle is outstanding
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cyc", 64'(cyc), 64'(0));
        chk("async_rst_stb", 64'(stb), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_tx_valid", 64'(tx_valid), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        do_read(32'h0000_0110, 1);
        wait_idle("read_after_reset", 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
